// File: rtl/frontend_pkg.sv
// Shared front-end definitions for the instruction buffer: widths, line geometry,
// FSM state encoding and the slot-PC helper.
package frontend_pkg;

  localparam int PC_W           = 48;
  localparam int INST_W         = 32;
  localparam int LINE_W         = 512;
  localparam int INSTS_PER_LINE = 16;
  localparam int LINE_OFF_LSB   = 2;
  localparam int LINE_OFF_MSB   = 5;
  localparam int SLOT_W         = LINE_OFF_MSB - LINE_OFF_LSB + 1;
  localparam int LINE_BYTES     = 1 << (LINE_OFF_MSB + 1);

  typedef enum logic [1:0] {
    WAIT_LINE = 2'd0,
    UNPACK    = 2'd1,
    REQ       = 2'd2
  } ibuf_state_e;

  // PC of slot k within a 64-byte aligned line; never carries out of the line.
  function automatic logic [PC_W-1:0] slot_pc(input logic [PC_W-1:0] base,
                                              input logic [SLOT_W-1:0] k);
    return base + PC_W'({k, 2'b00});
  endfunction

endpackage

// File: rtl/ibuf_fifo.sv
// Synchronous first-word-fall-through FIFO holding {pc, inst} entries.
// Flush empties it in one cycle and overrides any push/pop in that cycle.
module ibuf_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 80,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic          valid,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign valid   = (count_q != '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && valid && !flush;
  assign count   = count_q;
  // Head is forced to zero while empty so stale storage never shows on the outputs.
  assign head    = valid ? mem_q[rd_ptr_q] : '0;

  // Next pointer/occupancy; pointers wrap naturally modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ibuffer.sv
// Instruction buffer: captures a fetched 64-byte line, unpacks it slot by slot into
// a FIFO of {pc, inst} for the decoder, and requests the next sequential line once
// there is room for a whole line. clear_ibuffer flushes everything immediately.
module ibuffer
  import frontend_pkg::*;
#(
  parameter int DEPTH   = 32,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [PC_W-1:0]   pc,
  input  logic              pc_operation_done,
  input  logic [LINE_W-1:0] pc_read_inst,
  input  logic              clear_ibuffer,
  output logic              fetch_inst,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  output logic [CNT_W-1:0]  ibuf_count
);

  localparam logic [CNT_W-1:0]  REQ_MAX_CNT = CNT_W'(DEPTH - INSTS_PER_LINE);
  localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(INSTS_PER_LINE - 1);
  localparam logic [PC_W-1:0]   LINE_MASK   = PC_W'(LINE_BYTES - 1);

  ibuf_state_e         state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [PC_W-1:0]     base_q, base_d;
  logic [SLOT_W-1:0]   k_q, k_d;

  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_valid;
  logic                room_for_line;
  logic [PC_W+INST_W-1:0] push_data;
  logic [PC_W+INST_W-1:0] head;

  assign room_for_line = (ibuf_count <= REQ_MAX_CNT);
  assign pop           = fifo_valid && inst_ready;
  assign push_data     = {slot_pc(base_q, k_q), line_q[k_q*INST_W +: INST_W]};
  assign inst_valid    = fifo_valid;
  assign inst_pc       = head[PC_W+INST_W-1:INST_W];
  assign inst          = head[INST_W-1:0];

  ibuf_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + INST_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (clear_ibuffer),
    .full      (fifo_full),
    .valid     (fifo_valid),
    .head      (head),
    .count     (ibuf_count)
  );

  // FSM next state, line capture, slot advance and fetch request; clear overrides all.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    base_d     = base_q;
    k_d        = k_q;
    push       = 1'b0;
    fetch_inst = 1'b0;
    if (clear_ibuffer) begin
      state_d = WAIT_LINE;
      k_d     = '0;
    end else begin
      case (state_q)
        WAIT_LINE: begin
          if (pc_operation_done) begin
            line_d  = pc_read_inst;
            base_d  = pc & ~LINE_MASK;
            // Redirect into the middle of a line starts at the addressed slot.
            k_d     = pc[LINE_OFF_MSB:LINE_OFF_LSB];
            state_d = UNPACK;
          end
        end
        UNPACK: begin
          if (!fifo_full) begin
            push = 1'b1;
            k_d  = k_q + 1'b1;
            if (k_q == LAST_SLOT) state_d = REQ;
          end
        end
        REQ: begin
          if (room_for_line) begin
            fetch_inst = 1'b1;
            state_d    = WAIT_LINE;
          end
        end
        default: state_d = WAIT_LINE;
      endcase
    end
  end

  // Control registers: FSM state and slot counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_LINE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Line data and its base PC; only read while UNPACK, so left unreset.
  always_ff @(posedge clock) begin
    line_q <= line_d;
    base_q <= base_d;
  end

endmodule
